// File: rtl/gray_counter_ud_if.sv
// Control and status bundle for gray_counter_ud.
// The master drives count controls and the slave (counter) drives the count and status.
interface gray_counter_ud_if #(
    parameter int CBITS = 8
);
    logic             en;
    logic             up;
    logic             load;
    logic [CBITS-1:0] load_val;
    logic [CBITS-1:0] bin_c;
    logic [CBITS-1:0] gray_c;
    logic             wrap;
    logic             sat;
    logic             zero;

    modport master (
        output en, up, load, load_val,
        input  bin_c, gray_c, wrap, sat, zero
    );

    modport slave (
        input  en, up, load, load_val,
        output bin_c, gray_c, wrap, sat, zero
    );
endinterface

// File: rtl/gray_counter_ud.sv
// Up/down binary counter with a registered Gray-code copy, load, wrap or saturate ends.
// One cycle from en/load to the new count; no backpressure, zero is combinational.
module gray_counter_ud #(
    parameter int          CBITS = 8,
    parameter bit          WRAP  = 1'b1,
    parameter int unsigned INIT  = 0
) (
    input  logic              clk,
    input  logic              rst,
    gray_counter_ud_if.slave  bus
);
    localparam logic [CBITS-1:0] INIT_V = CBITS'(INIT);
    localparam logic [CBITS-1:0] MAX_V  = '1;

    logic [CBITS-1:0] bin_q,  bin_d;
    logic [CBITS-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             sat_q,  sat_d;

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        sat_d  = sat_q;
        if (bus.load) begin
            bin_d = bus.load_val;
            sat_d = 1'b0;
        end else if (bus.en) begin
            if (bus.up) begin
                if (bin_q == MAX_V) begin
                    if (WRAP) begin
                        bin_d  = '0;
                        wrap_d = 1'b1;
                        sat_d  = 1'b0;
                    end else begin
                        sat_d = 1'b1;
                    end
                end else begin
                    bin_d = bin_q + 1'b1;
                    sat_d = 1'b0;
                end
            end else begin
                if (bin_q == '0) begin
                    if (WRAP) begin
                        bin_d  = MAX_V;
                        wrap_d = 1'b1;
                        sat_d  = 1'b0;
                    end else begin
                        sat_d = 1'b1;
                    end
                end else begin
                    bin_d = bin_q - 1'b1;
                    sat_d = 1'b0;
                end
            end
        end
        // Encode from the next value so gray_q never lags bin_q by a cycle.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= INIT_V;
            gray_q <= INIT_V ^ (INIT_V >> 1);
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
        end
    end

    assign bus.bin_c  = bin_q;
    assign bus.gray_c = gray_q;
    assign bus.wrap   = wrap_q;
    assign bus.sat    = sat_q;
    assign bus.zero   = (bin_q == '0) & ~rst;
endmodule

// File: tb/tb_gray_counter_ud.sv
// Bench for gray_counter_ud: a wrapping (INIT=0) and a saturating (INIT=5) instance
// share stimulus and are compared every cycle against an integer reference model.
module tb_gray_counter_ud;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    gray_counter_ud_if #(.CBITS(4)) if0 ();
    gray_counter_ud_if #(.CBITS(4)) if1 ();

    gray_counter_ud #(.CBITS(4), .WRAP(1'b1), .INIT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    gray_counter_ud #(.CBITS(4), .WRAP(1'b0), .INIT(5)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    // Reference state: index 0 wraps from INIT 0, index 1 saturates from INIT 5.
    int m_cnt [2];
    int m_wrap[2];
    int m_sat [2];

    function automatic int init_of(input int i);
        return (i == 0) ? 0 : 5;
    endfunction

    function automatic bit wraps(input int i);
        return (i == 0);
    endfunction

    function automatic int gray_of(input int x);
        return x ^ (x / 2);
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = init_of(i);
            m_wrap[i] = 0;
            m_sat[i]  = 0;
        end
    endtask

    task automatic model_edge(input bit e, input bit u, input bit l, input int v);
        int nxt;
        for (int i = 0; i < 2; i++) begin
            if (l) begin
                m_cnt[i] = v; m_wrap[i] = 0; m_sat[i] = 0;
            end else if (e) begin
                nxt = u ? m_cnt[i] + 1 : m_cnt[i] - 1;
                if (nxt < 0 || nxt > 15) begin
                    if (wraps(i)) begin
                        m_cnt[i] = (nxt + 16) % 16; m_wrap[i] = 1; m_sat[i] = 0;
                    end else begin
                        m_wrap[i] = 0; m_sat[i] = 1;
                    end
                end else begin
                    m_cnt[i] = nxt; m_wrap[i] = 0; m_sat[i] = 0;
                end
            end else begin
                m_wrap[i] = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_bin0"},  int'(if0.bin_c),  m_cnt[0]);
        chk({tag, "_gray0"}, int'(if0.gray_c), gray_of(m_cnt[0]));
        chk({tag, "_wrap0"}, int'(if0.wrap),   m_wrap[0]);
        chk({tag, "_sat0"},  int'(if0.sat),    m_sat[0]);
        chk({tag, "_zero0"}, int'(if0.zero),   int'(m_cnt[0] == 0 && !rst));
        chk({tag, "_bin1"},  int'(if1.bin_c),  m_cnt[1]);
        chk({tag, "_gray1"}, int'(if1.gray_c), gray_of(m_cnt[1]));
        chk({tag, "_wrap1"}, int'(if1.wrap),   m_wrap[1]);
        chk({tag, "_sat1"},  int'(if1.sat),    m_sat[1]);
        chk({tag, "_zero1"}, int'(if1.zero),   int'(m_cnt[1] == 0 && !rst));
    endtask

    task automatic drive(input bit e, input bit u, input bit l, input logic [3:0] v);
        if0.en = e; if0.up = u; if0.load = l; if0.load_val = v;
        if1.en = e; if1.up = u; if1.load = l; if1.load_val = v;
    endtask

    // Called at a negedge: apply inputs, let one posedge happen, check at the next negedge.
    task automatic cycle(input bit e, input bit u, input bit l, input logic [3:0] v);
        logic [3:0] pg0;
        pg0 = if0.gray_c;
        drive(e, u, l, v);
        @(posedge clk);
        model_edge(e, u, l, int'(v));
        @(negedge clk);
        check_all("cyc");
        if (e && !l)
            chk("gstep0", $countones(if0.gray_c ^ pg0), 1);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        check_all({tag, "_hold"});
        rst = 1'b0;
        #1 check_all({tag, "_rel"});
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        model_reset();
        @(negedge clk);
        #1 check_all("rst");
        @(negedge clk);
        rst = 1'b0;
        #1 check_all("rel");

        // Count up through a full period and back to zero.
        for (int k = 0; k < 16; k++) cycle(1'b1, 1'b1, 1'b0, 4'd0);
        chk("t1_bin",  int'(if0.bin_c), 0);
        chk("t1_wrap", int'(if0.wrap), 1);
        chk("t1_zero", int'(if0.zero), 1);
        chk("t1_sat1", int'(if1.bin_c), 15);

        // Down from zero wraps to max.
        cycle(1'b1, 1'b0, 1'b0, 4'd0);
        chk("t2_bin",  int'(if0.bin_c), 15);
        chk("t2_gray", int'(if0.gray_c), 8);
        chk("t2_wrap", int'(if0.wrap), 1);
        cycle(1'b1, 1'b0, 1'b0, 4'd0);
        chk("t2_bin14",  int'(if0.bin_c), 14);
        chk("t2_wrap14", int'(if0.wrap), 0);

        // Saturation on the non-wrapping instance, then reverse.
        cycle(1'b0, 1'b1, 1'b1, 4'd12);
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b1, 1'b0, 4'd0);
        chk("t3_bin", int'(if1.bin_c), 15);
        chk("t3_sat", int'(if1.sat), 1);
        cycle(1'b0, 1'b1, 1'b0, 4'd0);
        chk("t3_sat_hold", int'(if1.sat), 1);
        cycle(1'b1, 1'b0, 1'b0, 4'd0);
        chk("t3_down", int'(if1.bin_c), 14);
        chk("t3_clr",  int'(if1.sat), 0);

        // Load has priority over counting.
        cycle(1'b1, 1'b1, 1'b1, 4'd9);
        chk("t4_bin",  int'(if0.bin_c), 9);
        chk("t4_gray", int'(if0.gray_c), 13);

        // Asynchronous reset in the middle of a count.
        cycle(1'b0, 1'b1, 1'b1, 4'd11);
        cycle(1'b1, 1'b1, 1'b0, 4'd0);
        async_reset("t5");
        chk("t5_bin",  int'(if1.bin_c), 5);
        chk("t5_gray", int'(if1.gray_c), 7);
        cycle(1'b1, 1'b1, 1'b0, 4'd0);
        chk("t5_first", int'(if1.bin_c), 6);

        // Randomised traffic, with occasional loads and mid-cycle resets.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rnd_rst");
            end else begin
                cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                      ($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
